gpio_port_debounced: RTL and testbench

Memory-mapped 32-bit bidirectional GPIO peripheral that drives and samples the microcontroller's `port_io` pins. It sits between the MIPS data-memory bus decoder and the external pins. Push buttons on the low input bits are synchronized and debounced before the core sees them, and rising edges on input bits raise a maskable interrupt request toward the core.

---
 rtl/gpio_port_debounced.sv | 144 ++++++++++++++
 tb/tb_gpio_port_debounced.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_port_debounced.sv
// gpio_port_debounced: memory-mapped bidirectional GPIO port.
// Inputs are synchronized and debounced; rising edges on input bits set
// flags that raise a maskable, registered interrupt request.
//
// Ports:
//   sys_clk  - system clock, rising edge
//   rst      - asynchronous active-low reset
//   cs, wr   - chip select and write strobe (write = cs & wr)
//   addr     - register index: 0 DATA, 1 DIR, 2 IRQ_MASK, 3 IRQ_FLAGS
//   data_in  - write data
//   data_out - combinational read data, 0 when cs = 0
//   port_io  - external pins, driven only where DIR = 1
//   irq      - registered interrupt request
module gpio_port_debounced #(
    parameter int unsigned WIDTH           = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 100
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             cs,
    input  logic             wr,
    input  logic [1:0]       addr,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    inout  wire  [WIDTH-1:0] port_io,
    output logic             irq
);

    localparam int unsigned PRESC_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_DIR   = 2'd1;
    localparam logic [1:0] ADDR_MASK  = 2'd2;
    localparam logic [1:0] ADDR_FLAGS = 2'd3;

    logic [WIDTH-1:0]   r_out;
    logic [WIDTH-1:0]   r_dir;
    logic [WIDTH-1:0]   r_mask;
    logic [WIDTH-1:0]   r_flag;
    logic [WIDTH-1:0]   r_deb;
    logic [WIDTH-1:0]   r_sync1;
    logic [WIDTH-1:0]   r_sync2;
    logic [WIDTH-1:0]   r_hist0;
    logic [WIDTH-1:0]   r_hist1;
    logic [WIDTH-1:0]   r_hist2;
    logic [PRESC_W-1:0] r_presc;
    logic               r_irq;

    logic               w_tick;
    logic               w_wr_en;
    logic [WIDTH-1:0]   w_stable;
    logic [WIDTH-1:0]   w_deb_next;
    logic [WIDTH-1:0]   w_rise;
    logic [WIDTH-1:0]   w_clr;
    logic [WIDTH-1:0]   w_flag_next;

    // Pin drive: only output-direction bits are driven.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pin
        assign port_io[gi] = r_dir[gi] ? r_out[gi] : 1'bz;
    end

    assign w_tick  = (r_presc == PRESC_W'(DEBOUNCE_CYCLES - 1));
    assign w_wr_en = cs & wr;

    // After the shift the history is {sync, hist0, hist1}; accept only if all agree.
    assign w_stable    = ~(r_sync2 ^ r_hist0) & ~(r_hist0 ^ r_hist1);
    assign w_deb_next  = w_tick ? ((w_stable & r_sync2) | (~w_stable & r_deb)) : r_deb;
    assign w_rise      = w_deb_next & ~r_deb & ~r_dir;
    assign w_clr       = (w_wr_en && (addr == ADDR_FLAGS)) ? data_in : '0;
    // A rise in the same cycle as a clear keeps the flag set.
    assign w_flag_next = (r_flag & ~w_clr) | w_rise;

    assign irq = r_irq;

    // Synchronizer, prescaler, sample history and debounced state.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_hist0 <= '0;
            r_hist1 <= '0;
            r_hist2 <= '0;
            r_presc <= '0;
            r_deb   <= '0;
        end else begin
            r_sync1 <= port_io;
            r_sync2 <= r_sync1;
            r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
            if (w_tick) begin
                r_hist0 <= r_sync2;
                r_hist1 <= r_hist0;
                r_hist2 <= r_hist1;
            end
            r_deb <= w_deb_next;
        end
    end

    // Software-visible configuration registers.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_out  <= '0;
            r_dir  <= '0;
            r_mask <= '0;
        end else if (w_wr_en) begin
            case (addr)
                ADDR_DATA: r_out  <= data_in;
                ADDR_DIR:  r_dir  <= data_in;
                ADDR_MASK: r_mask <= data_in;
                default:   ;
            endcase
        end
    end

    // Edge flags and interrupt request.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_flag <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_flag <= w_flag_next;
            r_irq  <= |(w_flag_next & r_mask);
        end
    end

    // Read mux.
    always_comb begin
        data_out = '0;
        if (cs) begin
            case (addr)
                ADDR_DATA:  data_out = (r_dir & r_out) | (~r_dir & r_deb);
                ADDR_DIR:   data_out = r_dir;
                ADDR_MASK:  data_out = r_mask;
                ADDR_FLAGS: data_out = r_flag;
                default:    data_out = '0;
            endcase
        end
    end

    // hist2 is kept for a complete three-deep history view; only the
    // two older entries feed the agreement test because sync is the newest.
    logic w_unused;
    assign w_unused = ^r_hist2;

endmodule

// File: tb/tb_gpio_port_debounced.sv
// Bench for gpio_port_debounced with DEBOUNCE_CYCLES = 4.
module tb_gpio_port_debounced;

    localparam int unsigned W = 32;
    localparam int D = 4;

    logic          sys_clk;
    logic          rst;
    logic          cs;
    logic          wr;
    logic [1:0]    addr;
    logic [W-1:0]  data_in;
    logic [W-1:0]  data_out;
    logic          irq;
    wire  [W-1:0]  port_io;
    logic [W-1:0]  tb_en;
    logic [W-1:0]  tb_drv;

    int n_cmp   = 0;
    int n_bad   = 0;
    int n_print = 0;

    for (genvar gi = 0; gi < W; gi++) begin : g_drv
        assign port_io[gi] = tb_en[gi] ? tb_drv[gi] : 1'bz;
    end

    gpio_port_debounced #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .cs      (cs),
        .wr      (wr),
        .addr    (addr),
        .data_in (data_in),
        .data_out(data_out),
        .port_io (port_io),
        .irq     (irq)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Behavioural model: debounced value derived from the pin value seen at
    // each edge since reset; ticks fall on every D-th edge after release.
    int           m_k    = 0;
    logic [W-1:0] m_out  = '0;
    logic [W-1:0] m_dir  = '0;
    logic [W-1:0] m_mask = '0;
    logic [W-1:0] m_flag = '0;
    logic [W-1:0] m_deb  = '0;
    logic         m_irq  = 1'b0;
    logic [W-1:0] pin_hist[$];

    function automatic logic [W-1:0] get_pin(input int j);
        if (j < 1 || j > pin_hist.size()) return '0;
        return pin_hist[j-1];
    endfunction

    function automatic logic [W-1:0] model_read(input logic c, input logic [1:0] a);
        if (!c) return '0;
        case (a)
            2'd0:    return (m_dir & m_out) | (~m_dir & m_deb);
            2'd1:    return m_dir;
            2'd2:    return m_mask;
            default: return m_flag;
        endcase
    endfunction

    always @(posedge sys_clk or negedge rst) begin
        int           k;
        logic [W-1:0] pinv, s0, s1, s2, deb_new, rise, clr, flag_new;
        if (!rst) begin
            m_k    <= 0;
            m_out  <= '0;
            m_dir  <= '0;
            m_mask <= '0;
            m_flag <= '0;
            m_deb  <= '0;
            m_irq  <= 1'b0;
            pin_hist.delete();
        end else begin
            k    = m_k + 1;
            pinv = (m_dir & m_out) | (~m_dir & tb_en & tb_drv);
            pin_hist.push_back(pinv);
            deb_new = m_deb;
            if (k % D == 0) begin
                s0 = get_pin(k - 2);
                s1 = get_pin(k - 2 - D);
                s2 = get_pin(k - 2 - 2 * D);
                for (int i = 0; i < W; i++)
                    if (s0[i] == s1[i] && s1[i] == s2[i]) deb_new[i] = s0[i];
            end
            rise     = deb_new & ~m_deb & ~m_dir;
            clr      = (cs && wr && addr == 2'd3) ? data_in : '0;
            flag_new = (m_flag & ~clr) | rise;
            m_irq  <= |(flag_new & m_mask);
            m_flag <= flag_new;
            m_deb  <= deb_new;
            m_k    <= k;
            if (cs && wr) begin
                case (addr)
                    2'd0:    m_out  <= data_in;
                    2'd1:    m_dir  <= data_in;
                    2'd2:    m_mask <= data_in;
                    default: ;
                endcase
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge sys_clk) begin
        logic [W-1:0] exp_d;
        exp_d = model_read(cs, addr);
        n_cmp++;
        if (data_out !== exp_d) begin
            n_bad++;
            if (n_print < 20) $display("FAIL model_data_out t=%0t got %h expected %h", $time, data_out, exp_d);
            n_print++;
        end
        n_cmp++;
        if (irq !== m_irq) begin
            n_bad++;
            if (n_print < 20) $display("FAIL model_irq t=%0t got %b expected %b", $time, irq, m_irq);
            n_print++;
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge sys_clk);
        #1;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [W-1:0] d);
        @(negedge sys_clk);
        #1;
        cs = 1'b1; wr = 1'b1; addr = a; data_in = d;
        @(negedge sys_clk);
        #1;
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [W-1:0] d);
        cs = 1'b1; wr = 1'b0; addr = a;
        #1;
        d = data_out;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] d;
        int n, k0, target;
        logic got;

        rst = 1'b0; cs = 1'b0; wr = 1'b0; addr = 2'd0; data_in = '0;
        tb_en = '1; tb_drv = 32'h5A5A_5A5A;

        // Reset: all reads 0, irq 0, pins carry only the bench's values.
        #20;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            check("reset_read", d, '0);
        end
        check("reset_irq", {31'd0, irq}, '0);
        check("reset_pins", port_io, 32'h5A5A_5A5A);
        #30;
        @(negedge sys_clk); #1;
        tb_drv = '0;
        @(negedge sys_clk); #1;
        rst = 1'b1;
        cycles(2);

        // Output path.
        tb_en = 32'h0000_000F;
        wr_reg(2'd1, 32'hFFFF_FFF0);
        wr_reg(2'd0, 32'hA5A5_A5A0);
        cycles(1);
        check("out_pins", {port_io[31:4], 4'h0}, 32'hA5A5_A5A0);
        check("in_pins", {28'd0, port_io[3:0]}, '0);
        rd(2'd0, d);
        check("data_read", d, 32'hA5A5_A5A0);

        // Glitch rejection on bit 0: 3-cycle then 7-cycle pulse.
        tb_drv[0] = 1'b1; cycles(3); tb_drv[0] = 1'b0;
        cycles(10);
        tb_drv[0] = 1'b1; cycles(7); tb_drv[0] = 1'b0;
        cycles(20);
        rd(2'd0, d);
        check("glitch_deb0", {31'd0, d[0]}, '0);
        rd(2'd3, d);
        check("glitch_flags", d, '0);
        check("glitch_irq", {31'd0, irq}, '0);

        // Debounce latency on bit 2.
        tb_drv[2] = 1'b1;
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(negedge sys_clk); #1;
            n++;
            rd(2'd0, d);
            if (d[2]) got = 1'b1;
        end
        check("lat_seen", {31'd0, got}, 32'd1);
        check("lat_window", {31'd0, (n >= 10 && n <= 14)}, 32'd1);
        rd(2'd3, d);
        check("lat_flag", d, 32'h4);
        check("lat_irq_unmasked", {31'd0, irq}, '0);

        // Return bit 2 low and clear all flags.
        tb_drv[2] = 1'b0;
        cycles(20);
        wr_reg(2'd3, 32'hFFFF_FFFF);
        rd(2'd3, d);
        check("flags_cleared", d, '0);

        // Interrupt flow.
        wr_reg(2'd2, 32'h4);
        tb_drv[2] = 1'b1;
        n = 0;
        while (irq !== 1'b1 && n < 40) begin
            @(negedge sys_clk); #1;
            n++;
        end
        check("irq_set", {31'd0, irq}, 32'd1);
        rd(2'd3, d);
        check("irq_flags", d, 32'h4);
        wr_reg(2'd3, 32'h4);
        check("irq_clear", {31'd0, irq}, '0);
        rd(2'd3, d);
        check("flags_after_w1c", d, '0);

        tb_drv[1] = 1'b1;
        cycles(20);
        rd(2'd3, d);
        check("unmasked_flag", d, 32'h2);
        check("unmasked_irq", {31'd0, irq}, '0);

        // Collision: W1C of bit 2 on the very edge its debounced value rises.
        tb_drv[2] = 1'b0;
        cycles(20);
        wr_reg(2'd3, 32'hFFFF_FFFF);
        k0 = m_k;
        tb_drv[2] = 1'b1;
        target = k0 + 3 + 2 * D;
        while (target % D != 0) target++;
        while (m_k < target - 1) @(negedge sys_clk);
        #1;
        rd(2'd3, d);
        check("coll_pre", d, '0);
        cs = 1'b1; wr = 1'b1; addr = 2'd3; data_in = 32'h4;
        @(negedge sys_clk); #1;
        cs = 1'b0; wr = 1'b0;
        rd(2'd3, d);
        check("coll_flag", d & 32'h4, 32'h4);
        check("coll_irq", {31'd0, irq}, 32'd1);

        cycles(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
